// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking zone controller.
package parking_pkg;

  typedef enum logic [1:0] {
    HS_IDLE     = 2'd0,
    HS_RESP     = 2'd1,
    HS_WAIT_LOW = 2'd2
  } hs_state_t;

  localparam int HOUR_W = 5;

  // Zone index width; a single-zone build still needs a one-bit index.
  function automatic int zone_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parking_zone_counter.sv
// Per-zone occupancy and capacity tracking with saturating counts and registered vacancy.
module parking_zone_counter #(
  parameter int              CNT_W   = 10,
  parameter logic [CNT_W-1:0] CAP_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             sched_we,
  input  logic [CNT_W-1:0] sched_cap,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_cap,
  output logic [CNT_W-1:0] occ,
  output logic [CNT_W-1:0] vac,
  output logic             avail,
  output logic             has_room,
  output logic             empty
);

  localparam logic [CNT_W-1:0] OCC_MAX = '1;

  logic [CNT_W-1:0] cap;
  logic [CNT_W-1:0] cap_nxt;
  logic [CNT_W-1:0] occ_nxt;
  logic [CNT_W-1:0] vac_nxt;
  logic             dec_ok;

  assign has_room = occ < cap;
  assign empty    = occ == '0;

  // A manual capacity write overrides a coincident schedule load; vacancy
  // is derived from the next-state values so it never lags occ or cap.
  always_comb begin
    cap_nxt = cap;
    occ_nxt = occ;
    dec_ok  = dec && !empty;
    if (cfg_we) begin
      cap_nxt = cfg_cap;
    end else if (sched_we) begin
      cap_nxt = sched_cap;
    end
    case ({inc, dec_ok})
      2'b10: begin
        if (occ != OCC_MAX) occ_nxt = occ + CNT_W'(1);
      end
      2'b01:   occ_nxt = occ - CNT_W'(1);
      default: occ_nxt = occ;
    endcase
    vac_nxt = (cap_nxt > occ_nxt) ? (cap_nxt - occ_nxt) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ   <= '0;
      cap   <= CAP_RST;
      vac   <= CAP_RST;
      avail <= |CAP_RST;
    end else begin
      occ   <= occ_nxt;
      cap   <= cap_nxt;
      vac   <= vac_nxt;
      avail <= vac_nxt != '0;
    end
  end

endmodule

// File: rtl/parking_zone_controller.sv
// Multi-zone parking controller: hour-based capacity schedule, entry/exit handshakes, overflow redirection.
module parking_zone_controller
  import parking_pkg::*;
#(
  parameter int                         NUM_ZONES       = 2,
  parameter int                         CNT_W           = 10,
  parameter int                         CLOCKS_PER_HOUR = 10,
  parameter int                         START_HOUR      = 8,
  parameter int                         DAY_HOUR        = 8,
  parameter int                         NIGHT_HOUR      = 16,
  parameter logic [NUM_ZONES*CNT_W-1:0] CAP_DAY         = {10'd500, 10'd200},
  parameter logic [NUM_ZONES*CNT_W-1:0] CAP_NIGHT       = {10'd200, 10'd500},
  parameter int                         OVF_ZONE        = 1,
  localparam int                        ZW              = zone_width(NUM_ZONES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ent_req,
  input  logic [ZW-1:0]              ent_zone,
  input  logic                       ovf_en,
  input  logic                       ex_req,
  input  logic [ZW-1:0]              ex_zone,
  input  logic                       cfg_we,
  input  logic [ZW-1:0]              cfg_zone,
  input  logic [CNT_W-1:0]           cfg_cap,
  output logic                       ent_grant,
  output logic                       ent_deny,
  output logic [ZW-1:0]              ent_gzone,
  output logic                       ex_ack,
  output logic                       err_underflow,
  output logic [NUM_ZONES*CNT_W-1:0] occ,
  output logic [NUM_ZONES*CNT_W-1:0] vac,
  output logic [NUM_ZONES-1:0]       avail,
  output logic [HOUR_W-1:0]          hour
);

  localparam int CLK_W = (CLOCKS_PER_HOUR > 1) ? $clog2(CLOCKS_PER_HOUR) : 1;
  localparam logic [NUM_ZONES*CNT_W-1:0] CAP_RST =
    (START_HOUR >= DAY_HOUR && START_HOUR < NIGHT_HOUR) ? CAP_DAY : CAP_NIGHT;
  localparam logic [ZW-1:0] OVF_IDX = ZW'(OVF_ZONE);

  logic [CLK_W-1:0]     clk_cnt;
  logic [HOUR_W-1:0]    hour_nxt;
  logic                 hour_tick;
  logic                 load_day;
  logic                 load_night;

  hs_state_t            ent_state, ent_state_nxt;
  hs_state_t            ex_state, ex_state_nxt;
  logic [ZW-1:0]        ent_zone_q;
  logic [ZW-1:0]        ex_zone_q;

  logic [NUM_ZONES-1:0] has_room;
  logic [NUM_ZONES-1:0] empty;
  logic [NUM_ZONES-1:0] inc;
  logic [NUM_ZONES-1:0] dec;
  logic                 ent_valid;
  logic                 ex_valid;
  logic                 prim_ok;
  logic                 ovf_ok;
  logic                 underflow_hit;

  assign hour_tick  = clk_cnt == CLK_W'(CLOCKS_PER_HOUR - 1);
  assign hour_nxt   = (hour == HOUR_W'(23)) ? '0 : hour + HOUR_W'(1);
  assign load_day   = hour_tick && (hour_nxt == HOUR_W'(DAY_HOUR));
  assign load_night = hour_tick && (hour_nxt == HOUR_W'(NIGHT_HOUR));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_cnt <= '0;
      hour    <= HOUR_W'(START_HOUR);
    end else if (hour_tick) begin
      clk_cnt <= '0;
      hour    <= hour_nxt;
    end else begin
      clk_cnt <= clk_cnt + CLK_W'(1);
    end
  end

  // The requested zone is captured on the IDLE->RESP step so the decision
  // in RESP is unaffected by later changes on the zone inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_state  <= HS_IDLE;
      ex_state   <= HS_IDLE;
      ent_zone_q <= '0;
      ex_zone_q  <= '0;
    end else begin
      ent_state <= ent_state_nxt;
      ex_state  <= ex_state_nxt;
      if (ent_state == HS_IDLE && ent_req) ent_zone_q <= ent_zone;
      if (ex_state == HS_IDLE && ex_req) ex_zone_q <= ex_zone;
    end
  end

  always_comb begin
    ent_state_nxt = ent_state;
    ex_state_nxt  = ex_state;
    case (ent_state)
      HS_IDLE:     if (ent_req) ent_state_nxt = HS_RESP;
      HS_RESP:     ent_state_nxt = HS_WAIT_LOW;
      HS_WAIT_LOW: if (!ent_req) ent_state_nxt = HS_IDLE;
      default:     ent_state_nxt = HS_IDLE;
    endcase
    case (ex_state)
      HS_IDLE:     if (ex_req) ex_state_nxt = HS_RESP;
      HS_RESP:     ex_state_nxt = HS_WAIT_LOW;
      HS_WAIT_LOW: if (!ex_req) ex_state_nxt = HS_IDLE;
      default:     ex_state_nxt = HS_IDLE;
    endcase
  end

  // Entry decisions use pre-exit occupancy, so a same-cycle exit on the
  // same zone nets to zero inside the counter.
  always_comb begin
    ent_valid     = int'(ent_zone_q) < NUM_ZONES;
    ex_valid      = int'(ex_zone_q) < NUM_ZONES;
    prim_ok       = ent_valid && has_room[ent_zone_q];
    ovf_ok        = ovf_en && has_room[OVF_ZONE];
    ent_grant     = (ent_state == HS_RESP) && (prim_ok || ovf_ok);
    ent_deny      = (ent_state == HS_RESP) && !(prim_ok || ovf_ok);
    ent_gzone     = '0;
    if (ent_grant) ent_gzone = prim_ok ? ent_zone_q : OVF_IDX;
    ex_ack        = ex_state == HS_RESP;
    underflow_hit = ex_ack && (!ex_valid || empty[ex_zone_q]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_underflow <= 1'b0;
    end else if (underflow_hit) begin
      err_underflow <= 1'b1;
    end
  end

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    assign inc[z] = ent_grant && (ent_gzone == ZW'(z));
    assign dec[z] = ex_ack && ex_valid && (ex_zone_q == ZW'(z));

    parking_zone_counter #(
      .CNT_W   (CNT_W),
      .CAP_RST (CAP_RST[z*CNT_W +: CNT_W])
    ) u_counter (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc[z]),
      .dec       (dec[z]),
      .sched_we  (load_day || load_night),
      .sched_cap (load_day ? CAP_DAY[z*CNT_W +: CNT_W] : CAP_NIGHT[z*CNT_W +: CNT_W]),
      .cfg_we    (cfg_we && (cfg_zone == ZW'(z))),
      .cfg_cap   (cfg_cap),
      .occ       (occ[z*CNT_W +: CNT_W]),
      .vac       (vac[z*CNT_W +: CNT_W]),
      .avail     (avail[z]),
      .has_room  (has_room[z]),
      .empty     (empty[z])
    );
  end

endmodule

// File: doc/parking_zone_controller.md
PARKING_ZONE_CONTROLLER -- requirements
Module: parking_zone_controller

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_ZONES, 2, number of independent zones.
REQ-002 CNT_W, 10, width of every count and capacity field.
REQ-003 CLOCKS_PER_HOUR, 10, clock cycles per simulated hour.
REQ-004 START_HOUR, 8, hour after reset; DAY_HOUR, 8, and NIGHT_HOUR, 16, are the schedule switch hours.
REQ-005 CAP_DAY / CAP_NIGHT, packed NUM_ZONES*CNT_W vectors, per-zone capacity in each window; default {200,500} day and {500,200} night (zone1 MSB).
REQ-006 OVF_ZONE, 1, zone that absorbs overflow entries.
REQ-007 Ports: clk, in, 1, clock; rst, in, 1, reset. The design SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-008 ent_req, in, 1, entry request (level); ent_zone, in, ZW, requested zone; ZW = max(1, clog2(NUM_ZONES)).
REQ-009 ovf_en, in, 1, enables overflow redirection.
REQ-010 ex_req, in, 1, exit request (level); ex_zone, in, ZW, zone being vacated.
REQ-011 cfg_we, in, 1, capacity write strobe; cfg_zone, in, ZW, target zone; cfg_cap, in, CNT_W, new capacity.
REQ-012 ent_grant, out, 1, one-cycle pulse; ent_deny, out, 1, one-cycle pulse; ent_gzone, out, ZW, zone granted, valid with ent_grant.
REQ-013 ex_ack, out, 1, one-cycle pulse; err_underflow, out, 1, sticky error flag.
REQ-014 occ, out, NUM_ZONES*CNT_W, per-zone occupancy; vac, out, NUM_ZONES*CNT_W, per-zone vacancy; avail, out, NUM_ZONES, vacancy > 0 per zone; hour, out, 5, current hour 0-23.

Function
REQ-015 Clock counter SHALL count 0..CLOCKS_PER_HOUR-1; on wrap, hour SHALL advance, 23 wrapping to 0.
REQ-016 When hour becomes DAY_HOUR, cap SHALL load CAP_DAY; when it becomes NIGHT_HOUR, cap SHALL load CAP_NIGHT.
REQ-017 cfg_we SHALL write cap[cfg_zone] in the next cycle; when a cfg_we write coincides with a schedule load, the cfg_we write SHALL win for that zone.
REQ-018 Entry and exit SHALL each have a three-state FSM: IDLE -> RESP -> WAIT_LOW -> IDLE.
REQ-019 In IDLE, ent_req=1 SHALL sample ent_zone and move to RESP; the grant/deny pulse SHALL assert in RESP, exactly 1 cycle after sampling.
REQ-020 WAIT_LOW SHALL hold until ent_req=0, giving one decision per request; exit SHALL follow the same rules with ex_ack.
REQ-021 An entry SHALL be granted in zone z when occ[z] < cap[z], and occ[z] SHALL increment.
REQ-022 Otherwise, if ovf_en=1 and occ[OVF_ZONE] < cap[OVF_ZONE], the entry SHALL be granted with ent_gzone = OVF_ZONE; otherwise ent_deny SHALL pulse.
REQ-023 An exit with occ[z] > 0 SHALL decrement occ[z]; an exit with occ[z] = 0 SHALL leave occ unchanged, set err_underflow, and still pulse ex_ack.
REQ-024 An entry and an exit decided in the same cycle on the same zone SHALL both apply (net 0); the entry check SHALL use the pre-exit occ.
REQ-025 A zone index >= NUM_ZONES SHALL cause deny (entry) or underflow (exit).
REQ-026 vac[z] SHALL equal cap[z] - occ[z], saturating at 0 when cap < occ (capacity shrink); occ SHALL never be trimmed.
REQ-027 occ SHALL saturate at 2^CNT_W-1; occ, vac and avail SHALL be registered.

Reset
REQ-028 While rst=0: occ=0, hour=START_HOUR, clock counter=0, both FSMs IDLE, all pulses 0, err_underflow=0.
REQ-029 While rst=0, cap SHALL be CAP_DAY if DAY_HOUR <= START_HOUR < NIGHT_HOUR, else CAP_NIGHT.
REQ-030 Reset asserted mid-handshake SHALL abort it with no count change; a request still held at release SHALL be treated as new.

Structure
REQ-031 Package parking_pkg SHALL hold the FSM state encodings, the hour width (5) and the function computing ZW.
REQ-032 One sub-module, parking_zone_counter (one instance per zone, via generate), SHALL hold occ/cap and the inc/dec/saturation logic.

Verification
REQ-033 After reset with START_HOUR=8: 200 zone-0 entries -> 200 grants; entry 201 -> ent_deny, vac[0]=0, avail[0]=0.
REQ-034 Zone 0 full, ovf_en=1 -> ent_grant with ent_gzone=1 and occ[1]+1; with ovf_en=0 -> ent_deny.
REQ-035 Exit on zone 1 with occ=0 -> ex_ack, occ[1]=0, err_underflow=1 held until reset.
REQ-036 Run 8*CLOCKS_PER_HOUR cycles -> hour=16, cap loads {500,200}; zone 1 with occ=300 -> vac[1]=0, occ[1]=300 retained.
REQ-037 ent_req held high 20 cycles -> exactly one grant; simultaneous entry and exit on zone 0 at occ=5 -> occ stays 5.
